multicycle_adder: RTL and testbench
===================================

Name: multicycle_adder

Overview:
- Parametrised successor to the team's fixed-width ripple adders: a WIDTH-bit add/subtract unit that processes CHUNK bits per clock and carries between chunks in a register.
- Trades latency for a short carry path, so wide datapaths can close timing without a wide ripple chain.
- Sits between the operand source and the result consumer, with valid/ready handshakes on both sides.
- Adds subtract mode and a signed-overflow flag.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; NCHUNK = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  high only in IDLE.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in; acts as borrow-in when Sub=1.
- Sub  in  1  0: A+B+Cin; 1: A-B-Cin.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- Sum  out  WIDTH  registered result.
- Cout  out  1  carry out of MSB; in subtract mode 1 = no borrow.
- Overflow  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset is asynchronous and active-high.
  - On reset: state=IDLE, chunk index k=0, carry register=0, internal accumulators=0.
  - Sum=0, Cout=0, Overflow=0, out_valid=0, busy=0.
  - in_ready=1 once state is IDLE, including while reset is held.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge, capture A into opA and (Sub ? ~B : B) into opB, set carry=Cin^Sub, k=0, go to RUN.
  - Sub=1 with Cin=0 therefore gives A-B; Sub=1 with Cin=1 gives A-B-1.
- RUN: each cycle,
  - {c, s} = opA[k*CHUNK +: CHUNK] + opB[k*CHUNK +: CHUNK] + carry, computed at CHUNK+1 bits.
  - Write s into accumulator chunk k; carry <= c.
  - On the final chunk (k=NCHUNK-1), also record the carry into the MSB for the overflow calculation.
  - When k=NCHUNK-1: load Sum from the accumulator with the final chunk merged, Cout=c, Overflow=c XOR carry-into-MSB, set out_valid=1, go to DONE. Otherwise k<=k+1.
- Latency: out_valid rises NCHUNK clock edges after the accepting edge; 4 for the defaults.
- DONE:
  - out_valid=1; Sum, Cout and Overflow are stable.
  - in_ready=0; in_valid is ignored.
  - On out_ready=1 at an edge: out_valid<=0, go to IDLE. The next operation can be accepted no earlier than the following edge.
- Between results, Sum, Cout and Overflow hold the last result. They change only on the RUN to DONE transition.
- Inputs A, B, Cin and Sub may change freely after acceptance; only the captured copies are used.
- Reset asserted mid-RUN or in DONE: the operation is aborted, all outputs return to reset values, and no partial result is ever presented.
- CHUNK=WIDTH is legal: a single RUN cycle, latency 1.
- k is sized to clog2(NCHUNK), minimum 1 bit.

Test Plan:
- Defaults, A=0xFFFFFFFF, B=0x00000001, Cin=0, Sub=0 -> after 4 cycles Sum=0x00000000, Cout=1, Overflow=0; carry propagates through all chunks.
- A=0x7FFFFFFF, B=0x00000001, Sub=0 -> Sum=0x80000000, Cout=0, Overflow=1. Then A=0x000000FF, B=0x00000001 -> Sum=0x00000100, Cout=0, Overflow=0.
- Subtract mode:
  - Sub=1, A=5, B=7, Cin=0 -> Sum=0xFFFFFFFE, Cout=0, Overflow=0.
  - Sub=1, A=0x80000000, B=1 -> Sum=0x7FFFFFFF, Cout=1, Overflow=1.
  - Sub=1, A=10, B=3, Cin=1 -> Sum=6, Cout=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid, and pulse in_valid with new operands during that time -> Sum held, in_ready=0, new operands ignored. Then out_ready=1 -> out_valid=0 next edge, in_ready=1.
- Assert reset 2 cycles into RUN -> out_valid=0, Sum=0, busy=0, and the FSM returns to IDLE immediately. A subsequent 3+4 add gives Sum=7 after 4 cycles.
- Parameter sweep with CHUNK=32, WIDTH=32 and CHUNK=4, WIDTH=16 (latency 1 and 4) -> 1000 random add/sub ops per configuration match a reference model for Sum, Cout and Overflow.

Source files
------------

// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit add/subtract evaluated CHUNK bits per clock with a registered inter-chunk carry
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake; in_ready is high only in IDLE
//   A, B, Cin, Sub        operands; Sub=1 computes A-B-Cin (Cin acts as borrow-in)
//   out_valid/out_ready   result handshake; result held until accepted
//   Sum, Cout, Overflow   registered result, carry out (1 = no borrow when subtracting), signed overflow
//   busy                  high while an operation is running or waiting to be accepted
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] opa, opb, acc, acc_n;
    logic [KW-1:0]    k;
    logic             carry, last, cmsb;
    logic [CHUNK-1:0] ca, cb;
    logic [CHUNK:0]   part;
    int               idx;

    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    assign last     = k == KW'(NCHUNK - 1);

    // The carry into the top bit of a chunk is recovered from its sum bit: s = a ^ b ^ cin.
    always_comb begin
        idx = int'(k) * CHUNK;
        ca = opa[idx +: CHUNK];
        cb = opb[idx +: CHUNK];
        part = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
        cmsb = ca[CHUNK-1] ^ cb[CHUNK-1] ^ part[CHUNK-1];
        acc_n = acc;
        acc_n[idx +: CHUNK] = part[CHUNK-1:0];
    end

    // Subtraction is A + ~B + 1 - Cin, so the initial carry is Cin ^ Sub.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            carry     <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            Sum       <= '0;
            Cout      <= 1'b0;
            Overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    opa   <= A;
                    opb   <= Sub ? ~B : B;
                    carry <= Cin ^ Sub;
                    k     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= acc_n;
                    carry <= part[CHUNK];
                    if (last) begin
                        Sum       <= acc_n;
                        Cout      <= part[CHUNK];
                        Overflow  <= part[CHUNK] ^ cmsb;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: scoreboard bench for multicycle_adder in the default, single-chunk and 16/4 configurations
module tb_multicycle_adder;
    typedef struct {logic [31:0] s; logic co; logic ov;} exp_t;

    logic clk = 1'b0, reset;
    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;

    logic        m_iv, m_ir, m_ci, m_sb, m_ov, m_ordy, m_co, m_of, m_busy;
    logic [31:0] m_a, m_b, m_sum;
    logic        s1_iv, s1_ir, s1_ci, s1_sb, s1_ov, s1_co, s1_of, s1_busy;
    logic [31:0] s1_a, s1_b, s1_sum;
    logic        s2_iv, s2_ir, s2_ci, s2_sb, s2_ov, s2_co, s2_of, s2_busy;
    logic [15:0] s2_a, s2_b, s2_sum;

    multicycle_adder dut (.clk(clk), .reset(reset), .in_valid(m_iv), .in_ready(m_ir), .A(m_a), .B(m_b),
        .Cin(m_ci), .Sub(m_sb), .out_valid(m_ov), .out_ready(m_ordy), .Sum(m_sum), .Cout(m_co),
        .Overflow(m_of), .busy(m_busy));
    multicycle_adder #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .reset(reset), .in_valid(s1_iv),
        .in_ready(s1_ir), .A(s1_a), .B(s1_b), .Cin(s1_ci), .Sub(s1_sb), .out_valid(s1_ov),
        .out_ready(1'b1), .Sum(s1_sum), .Cout(s1_co), .Overflow(s1_of), .busy(s1_busy));
    multicycle_adder #(.WIDTH(16), .CHUNK(4)) dut2 (.clk(clk), .reset(reset), .in_valid(s2_iv),
        .in_ready(s2_ir), .A(s2_a), .B(s2_b), .Cin(s2_ci), .Sub(s2_sb), .out_valid(s2_ov),
        .out_ready(1'b1), .Sum(s2_sum), .Cout(s2_co), .Overflow(s2_of), .busy(s2_busy));

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        logic [32:0] m, t;
        logic [31:0] bb;
        exp_t e;
        m = (33'h1 << w) - 33'h1;
        bb = (sb ? ~b : b) & m[31:0];
        t = {1'b0, a & m[31:0]} + {1'b0, bb} + {32'b0, ci ^ sb};
        e.s = t[31:0] & m[31:0];
        e.co = t[w];
        e.ov = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
        return e;
    endfunction

    always @(negedge clk) if (!reset && m_ov && m_ordy) begin
        if (q0.size() == 0) chk("m_unexpected", 32'd1, 32'd0);
        else begin
            e0 = q0.pop_front();
            chk("m_sum", m_sum, e0.s);
            chk("m_cout", {31'b0, m_co}, {31'b0, e0.co});
            chk("m_ovf", {31'b0, m_of}, {31'b0, e0.ov});
        end
    end

    always @(negedge clk) if (!reset && s1_ov) begin
        if (q1.size() == 0) chk("s1_unexpected", 32'd1, 32'd0);
        else begin
            e1 = q1.pop_front();
            chk("s1_sum", s1_sum, e1.s);
            chk("s1_cout", {31'b0, s1_co}, {31'b0, e1.co});
            chk("s1_ovf", {31'b0, s1_of}, {31'b0, e1.ov});
        end
    end

    always @(negedge clk) if (!reset && s2_ov) begin
        if (q2.size() == 0) chk("s2_unexpected", 32'd1, 32'd0);
        else begin
            e2 = q2.pop_front();
            chk("s2_sum", {16'b0, s2_sum}, e2.s);
            chk("s2_cout", {31'b0, s2_co}, {31'b0, e2.co});
            chk("s2_ovf", {31'b0, s2_of}, {31'b0, e2.ov});
        end
    end

    // Called at posedge+1 with the default DUT idle; returns with the result accepted when out_ready=1.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                        input logic [31:0] es, input logic eco, input logic eov);
        int lat;
        m_iv = 1'b1; m_a = a; m_b = b; m_ci = ci; m_sb = sb;
        q0.push_back('{es, eco, eov});
        @(posedge clk); #1;
        m_iv = 1'b0; m_a = $urandom; m_b = $urandom; m_ci = 1'b1; m_sb = ~sb;
        lat = 0;
        while (!m_ov && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", 32'(lat), 32'd4);
        if (m_ordy) begin @(posedge clk); #1; end
    endtask

    task automatic sweep1();
        int n, lat;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (!s1_ir && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) begin chk("s1_timeout", 32'(n), 32'd0); break; end
            s1_a = (i % 7 == 0) ? 32'h7FFFFFFF : $urandom;
            s1_b = (i % 3 == 0) ? s1_a : $urandom;
            s1_ci = 1'($urandom_range(1)); s1_sb = 1'($urandom_range(1));
            q1.push_back(model(32, s1_a, s1_b, s1_ci, s1_sb));
            s1_iv = 1'b1;
            @(posedge clk); #1;
            s1_iv = 1'b0;
            lat = 0;
            while (!s1_ov && lat < 20) begin @(posedge clk); #1; lat++; end
            if (i < 10) chk("s1_latency", 32'(lat), 32'd1);
        end
    endtask

    task automatic sweep2();
        int n, lat;
        for (int i = 0; i < 1000; i++) begin
            n = 0;
            while (!s2_ir && n < 50) begin @(posedge clk); #1; n++; end
            if (n >= 50) begin chk("s2_timeout", 32'(n), 32'd0); break; end
            s2_a = (i % 7 == 0) ? 16'h8000 : 16'($urandom);
            s2_b = (i % 3 == 0) ? ~s2_a : 16'($urandom);
            s2_ci = 1'($urandom_range(1)); s2_sb = 1'($urandom_range(1));
            q2.push_back(model(16, {16'b0, s2_a}, {16'b0, s2_b}, s2_ci, s2_sb));
            s2_iv = 1'b1;
            @(posedge clk); #1;
            s2_iv = 1'b0;
            lat = 0;
            while (!s2_ov && lat < 20) begin @(posedge clk); #1; lat++; end
            if (i < 10) chk("s2_latency", 32'(lat), 32'd4);
        end
    endtask

    initial begin
        reset = 1'b1; m_iv = 1'b0; m_ordy = 1'b1; m_a = '0; m_b = '0; m_ci = 1'b0; m_sb = 1'b0;
        s1_iv = 1'b0; s1_a = '0; s1_b = '0; s1_ci = 1'b0; s1_sb = 1'b0;
        s2_iv = 1'b0; s2_a = '0; s2_b = '0; s2_ci = 1'b0; s2_sb = 1'b0;
        #12;
        chk("rst_sum", m_sum, 32'd0);
        chk("rst_flags", {28'b0, m_co, m_of, m_ov, m_busy}, 32'd0);
        chk("rst_in_ready", {31'b0, m_ir}, 32'd1);
        @(posedge clk); #1; reset = 1'b0;
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        send(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
        send(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
        send(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        send(32'h80000000, 32'd1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        send(32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);
        send(32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
        m_ordy = 1'b0;
        send(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            m_iv = 1'b1; m_a = 32'd1; m_b = 32'd1; m_sb = 1'b0; m_ci = 1'b0;
            @(posedge clk); #1;
            chk("bp_sum_held", m_sum, 32'h23456789);
            chk("bp_in_ready", {31'b0, m_ir}, 32'd0);
            chk("bp_out_valid", {31'b0, m_ov}, 32'd1);
        end
        m_iv = 1'b0; m_ordy = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'b0, m_ov}, 32'd0);
        chk("bp_release_ready", {31'b0, m_ir}, 32'd1);
        m_iv = 1'b1; m_a = 32'd100; m_b = 32'd200; m_ci = 1'b0; m_sb = 1'b0;
        @(posedge clk); #1; m_iv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        chk("abort_valid", {31'b0, m_ov}, 32'd0);
        chk("abort_sum", m_sum, 32'd0);
        chk("abort_busy", {31'b0, m_busy}, 32'd0);
        chk("abort_in_ready", {31'b0, m_ir}, 32'd1);
        @(posedge clk); #1; reset = 1'b0;
        send(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);
        sweep1();
        sweep2();
        repeat (10) @(posedge clk);
        #1;
        chk("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
